uart_core: RTL and testbench

Byte-oriented UART with 16-entry receive and transmit FIFOs, 8N1 framing, LSB first. It sits between a bus-side register bridge and the RX/TX pins. On the bus side it offers a first-word-fall-through receive FIFO and a push-only transmit FIFO. The bit period is derived from a system clock frequency and a baud rate, both fixed at elaboration.

---
 rtl/uart_core.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: byte-oriented 8N1 UART, LSB first, with 16-entry receive and transmit FIFOs.
//   Clk, Reset      : system clock, synchronous active-high reset
//   RX, Enable_rx   : serial input (idle high), receiver enable
//   rd_uart_en      : pop the receive FIFO head
//   RX_data, Empty  : receive FIFO head (first-word fall-through), receive FIFO empty
//   TX_data,        : byte pushed into the transmit FIFO while wr_uart_en is high
//   wr_uart_en
//   Full            : transmit FIFO full
//   TX              : serial output (idle high)
module uart_core #(
  parameter int unsigned C_BAUDRATE    = 115_200,
  parameter int unsigned C_SYSTEM_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RX,
  input  logic       Enable_rx,
  input  logic       rd_uart_en,
  output logic [7:0] RX_data,
  output logic       Empty,
  input  logic [7:0] TX_data,
  input  logic       wr_uart_en,
  output logic       Full,
  output logic       TX
);

  localparam int unsigned BaudDiv = C_SYSTEM_FREQ / C_BAUDRATE;
  localparam int unsigned CntW    = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BaudDiv / 2 - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Receive path
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_mem_q [16];
  logic [7:0]      rx_mem_d [16];
  logic [4:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic            rx_push, rx_full, rx_empty, rx_wr, rx_rd, rx_fall;

  // Transmit path
  logic [1:0]      tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      tx_mem_q [16];
  logic [7:0]      tx_mem_d [16];
  logic [4:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic            tx_q, tx_d, tx_pop, tx_full, tx_empty, tx_wr;

  assign rx_fall  = rx_prev_q & ~rx_sync_q;
  assign rx_full  = (rx_wptr_q[4] != rx_rptr_q[4]) && (rx_wptr_q[3:0] == rx_rptr_q[3:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign tx_full  = (tx_wptr_q[4] != tx_rptr_q[4]) && (tx_wptr_q[3:0] == tx_rptr_q[3:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);

  assign RX_data = rx_mem_q[rx_rptr_q[3:0]];
  assign Empty   = rx_empty;
  assign Full    = tx_full;
  assign TX      = tx_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = StStart;
      end
      StStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // Line back high at mid start bit: treat the edge as a glitch.
          rx_state_d = rx_sync_q ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_push    = rx_sync_q;  // framing error drops the byte
          rx_state_d = StIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
    endcase
    if (!Enable_rx) begin
      rx_state_d = StIdle;
      rx_cnt_d   = '0;
      rx_push    = 1'b0;
    end
  end

  always_comb begin
    rx_wr     = rx_push & ~rx_full;
    rx_rd     = rd_uart_en & ~rx_empty;
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q + {4'd0, rx_wr};
    rx_rptr_d = rx_rptr_q + {4'd0, rx_rd};
    if (rx_wr) rx_mem_d[rx_wptr_q[3:0]] = rx_shift_q;
  end

  always_comb begin
    tx_wr      = wr_uart_en & ~tx_full;
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q + {4'd0, tx_wr};
    if (tx_wr) tx_mem_d[tx_wptr_q[3:0]] = TX_data;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rptr_q[3:0]];
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = StData;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = StStop;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so frames are gapless.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rptr_q[3:0]];
            tx_state_d = StStart;
          end else begin
            tx_state_d = StIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
    endcase
    tx_rptr_d = tx_rptr_q + {4'd0, tx_pop};
    // Register the pin from the next state so TX is a clean flop output.
    case (tx_state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_wptr_q  <= 5'd0;
      rx_rptr_q  <= 5'd0;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_wptr_q  <= 5'd0;
      tx_rptr_q  <= 5'd0;
      tx_q       <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        rx_mem_q[i] <= 8'd0;
        tx_mem_q[i] <= 8'd0;
      end
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_q       <= tx_d;
      rx_mem_q   <= rx_mem_d;
      tx_mem_q   <= tx_mem_d;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core.
// Runs the core at 12 clocks per bit (1 MHz / 83_333 baud, truncated) to keep frames short.
module tb_uart_core;

  localparam int unsigned Freq = 1_000_000;
  localparam int unsigned Baud = 83_333;
  localparam int          BD   = 12;

  logic       Clk, Reset, RX, Enable_rx, rd_uart_en, wr_uart_en;
  logic [7:0] RX_data, TX_data;
  logic       Empty, Full, TX;

  uart_core #(
    .C_BAUDRATE   (Baud),
    .C_SYSTEM_FREQ(Freq)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .RX        (RX),
    .Enable_rx (Enable_rx),
    .rd_uart_en(rd_uart_en),
    .RX_data   (RX_data),
    .Empty     (Empty),
    .TX_data   (TX_data),
    .wr_uart_en(wr_uart_en),
    .Full      (Full),
    .TX        (TX)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_model[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one 8N1 frame on RX; a good, enabled frame lands in the model if there is room.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_rx);
    RX = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) tick();
    end
    RX = stop;
    repeat (BD) tick();
    RX = 1'b1;
    repeat (2) tick();
    if (expect_rx && stop && rx_model.size() < 16) rx_model.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    exp = rx_model.pop_front();
    check_eq({tag, "_empty"}, 32'(Empty), 0);
    check_eq({tag, "_data"}, 32'(RX_data), 32'(exp));
    rd_uart_en = 1'b1;
    tick();
    rd_uart_en = 1'b0;
  endtask

  // Wait up to max_wait cycles for the start bit, then check every bit at its first and last cycle.
  task automatic check_tx_frame(input logic [7:0] b, input int max_wait);
    logic [9:0] bits;
    int waited;
    bits   = {1'b1, b, 1'b0};
    waited = 0;
    while (TX !== 1'b0 && waited < max_wait) begin
      tick();
      waited++;
    end
    check_eq("tx_start", 32'(TX), 0);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("tx_bit%0d_first", k), 32'(TX), 32'(bits[k]));
      repeat (BD - 1) tick();
      check_eq($sformatf("tx_bit%0d_last", k), 32'(TX), 32'(bits[k]));
      tick();
    end
  endtask

  task automatic tx_idle_check(input string tag, input int cycles);
    int low = 0;
    repeat (cycles) begin
      if (TX !== 1'b1) low++;
      tick();
    end
    check_eq(tag, 32'(low), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] fixed [8];
    logic [7:0] wbytes [18];
    logic       exp_full [18];
    logic [7:0] exp_tx[$];
    int         lvl;
    logic       busy;
    logic       pop, push;

    fixed = '{8'h7E, 8'h55, 8'hFE, 8'hFF, 8'h33, 8'h48, 8'h81, 8'h42};
    Reset = 1'b1; RX = 1'b1; Enable_rx = 1'b0; rd_uart_en = 1'b0;
    wr_uart_en = 1'b0; TX_data = 8'd0;
    repeat (3) tick();
    check_eq("rst_tx", 32'(TX), 1);
    check_eq("rst_empty", 32'(Empty), 1);
    check_eq("rst_full", 32'(Full), 0);
    check_eq("rst_rxdata", 32'(RX_data), 0);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("idle_tx", 32'(TX), 1);
      check_eq("idle_empty", 32'(Empty), 1);
      check_eq("idle_full", 32'(Full), 0);
      check_eq("idle_rxdata", 32'(RX_data), 0);
    end

    // Eight fixed frames, then read back in order.
    Enable_rx = 1'b1;
    foreach (fixed[i]) send_frame(fixed[i], 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) pop_check("fixed_pop");
    check_eq("fixed_empty_after", 32'(Empty), 1);
    rd_uart_en = 1'b1;
    tick();
    rd_uart_en = 1'b0;
    check_eq("pop_while_empty", 32'(Empty), 1);

    // Overflow: 17 random frames, only 16 kept.
    for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    check_eq("ovf_model_depth", 32'(rx_model.size()), 16);
    for (int i = 0; i < 16; i++) pop_check("ovf_pop");
    check_eq("ovf_empty_after", 32'(Empty), 1);

    // Framing error, glitch, and disabled receiver must not push.
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (BD) tick();
    check_eq("frame_err_empty", 32'(Empty), 1);
    RX = 1'b0;
    repeat (BD / 5) tick();
    RX = 1'b1;
    repeat (12 * BD) tick();
    check_eq("glitch_empty", 32'(Empty), 1);
    Enable_rx = 1'b0;
    send_frame(8'($urandom), 1'b1, 1'b0);
    check_eq("disabled_empty", 32'(Empty), 1);
    Enable_rx = 1'b1;
    repeat (BD) tick();
    send_frame(8'($urandom), 1'b1, 1'b1);
    pop_check("recover_pop");

    // Single 0xA5 transmit with exact bit timing.
    TX_data = 8'hA5;
    wr_uart_en = 1'b1;
    tick();
    wr_uart_en = 1'b0;
    check_tx_frame(8'hA5, 2);
    tx_idle_check("a5_idle_after", 2 * BD);

    // Burst of 18 writes: model the FIFO level with the transmitter taking the first byte.
    lvl  = 0;
    busy = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wbytes[i] = 8'($urandom);
      pop  = !busy && lvl > 0;
      push = lvl < 16;
      if (push) exp_tx.push_back(wbytes[i]);
      lvl = lvl + int'(push) - int'(pop);
      if (pop) busy = 1'b1;
      exp_full[i] = (lvl == 16);
    end
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          TX_data    = wbytes[i];
          wr_uart_en = 1'b1;
          tick();
          check_eq($sformatf("burst_full%0d", i), 32'(Full), 32'(exp_full[i]));
        end
        wr_uart_en = 1'b0;
      end
      begin
        for (int k = 0; k < 17; k++) check_tx_frame(exp_tx[k], (k == 0) ? 3 : 0);
      end
    join
    tx_idle_check("burst_idle_after", 3 * BD);
    check_eq("burst_full_drained", 32'(Full), 0);

    // Reset mid-transmit and mid-receive.
    for (int i = 0; i < 3; i++) begin
      TX_data    = 8'h00;
      wr_uart_en = 1'b1;
      tick();
    end
    wr_uart_en = 1'b0;
    send_frame(8'($urandom), 1'b1, 1'b1);
    check_eq("pre_rst_rx_nonempty", 32'(Empty), 0);
    RX = 1'b0;
    repeat (BD + 3) tick();
    check_eq("pre_rst_tx_low", 32'(TX), 0);
    Reset = 1'b1;
    RX    = 1'b1;
    tick();
    check_eq("midrst_tx", 32'(TX), 1);
    check_eq("midrst_empty", 32'(Empty), 1);
    check_eq("midrst_full", 32'(Full), 0);
    check_eq("midrst_rxdata", 32'(RX_data), 0);
    Reset = 1'b0;
    rx_model.delete();
    tx_idle_check("midrst_tx_idle", 3 * BD);
    check_eq("midrst_still_empty", 32'(Empty), 1);
    send_frame(8'($urandom), 1'b1, 1'b1);
    pop_check("post_rst_pop");
    check_eq("post_rst_empty", 32'(Empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
